program_step_sequencer: RTL and testbench
=========================================

// Module: program_step_sequencer
// PURPOSE
// Upstream stimulus stage for Bitblaster_10Bit_Processor. Replaces manual switch/button operation.
// Holds a small program image of per-timestep switch words. Presents each word on the processor's
// Raw_Data_From_Switches and generates a debouncer-safe Clock_Button pulse for it. Checks the
// processor's LED_D_Done where the program says an instruction must finish.
// PARAMETERS
// DEPTH         64         program entries; ADDR_W = $clog2(DEPTH)
// SETUP_CYCLES  4          Clock_50MHz cycles switch data is stable before pulse rises
// PULSE_CYCLES  2_500_000  Step_Clock high time (50 ms, exceeds input-logic debounce)
// GAP_CYCLES    2_500_000  Step_Clock low time after each pulse
// DONE_TIMEOUT  5_000_000  max cycles after pulse fall to see Done on an expect_done entry
// PORTS
// Clock_50MHz      in   1       system clock
// Reset            in   1       asynchronous, active-high reset
// Prog_Write_En    in   1       write program entry (accepted only in IDLE/HALTED/ERROR)
// Prog_Write_Addr  in   ADDR_W  entry address
// Prog_Write_Data  in   12      {halt, expect_done, switch_word[9:0]}
// Start            in   1       1-cycle pulse: run from entry 0
// Single_Step      in   1       1 = pause after each entry until Step_Request
// Step_Request     in   1       1-cycle pulse: release one paused entry
// Abort            in   1       1-cycle pulse: return to IDLE from any state
// Proc_Done        in   1       processor LED_D_Done (asynchronous to us; 2-flop synchronised)
// Switch_Data      out  10      drives processor Raw_Data_From_Switches
// Step_Clock       out  1       drives processor Clock_Button (high = pressed)
// Busy             out  1       1 in SETUP/PULSE_HI/PULSE_LO/WAIT_DONE/PAUSE
// Halted           out  1       program finished normally
// Error            out  1       Done timeout
// PC               out  ADDR_W  index of current entry
// BEHAVIOUR
// - Reset (async): state IDLE, PC=0, Switch_Data=0, Step_Clock=0, Busy=0, Halted=0, Error=0.
// - Program memory is not cleared by reset. Write is synchronous, one entry per cycle.
// - Writes outside IDLE/HALTED/ERROR are dropped.
// - States: IDLE, SETUP, PULSE_HI, PULSE_LO, WAIT_DONE, PAUSE, HALTED, ERROR.
// - IDLE/HALTED/ERROR + Start -> SETUP. PC=0. Halted and Error clear.
// - Start in any other state is ignored.
// - SETUP: Switch_Data = mem[PC][9:0], registered on entry to SETUP. Hold SETUP_CYCLES cycles -> PULSE_HI.
// - PULSE_HI: Step_Clock=1 for exactly PULSE_CYCLES cycles -> PULSE_LO.
// - PULSE_LO: Step_Clock=0 for GAP_CYCLES cycles. Switch_Data is held throughout.
//   - expect_done=1 -> WAIT_DONE.
//   - expect_done=0 -> advance.
// - WAIT_DONE counts from the first PULSE_LO cycle.
//   - Synchronised Done=1 seen in PULSE_LO or WAIT_DONE -> advance once the gap completes.
//   - Counter reaches DONE_TIMEOUT without Done -> ERROR. Error=1, Busy=0, PC frozen.
// - Advance:
//   - halt=1 or PC==DEPTH-1 -> HALTED, Halted=1. PC does not wrap.
//   - Else PC+1; Single_Step=1 -> PAUSE, else -> SETUP.
// - PAUSE: Busy=1, Step_Clock=0. Step_Request -> SETUP. Other inputs except Abort/Reset ignored.
// - Abort, any state: next cycle IDLE, Step_Clock=0, Switch_Data=0, PC=0.
//   Abort beats Start and Step_Request in the same cycle.
// - Reset mid-pulse drops Step_Clock asynchronously. The processor sees a short press the debouncer rejects.
// - Step_Clock and Switch_Data are registered outputs; no combinational path from inputs.
// - Latency Start -> first Step_Clock rise = SETUP_CYCLES+1 cycles.
// TESTING (bench overrides SETUP=2, PULSE=4, GAP=4, TIMEOUT=20)
// - Load {0,0,0x010},{0,0,0x155},{1,1,0x000}, Start, model Done high after 3rd pulse
//   -> three 4-cycle pulses with data 0x010, 0x155, 0x000 stable across each; Halted=1, PC=2.
// - Same program, Proc_Done never rises -> Error=1 exactly 20 cycles after 3rd pulse falls; Busy=0.
// - Single_Step=1 -> PAUSE after entry 0, no further pulse until Step_Request; then entry 1 runs.
// - Abort during PULSE_HI -> Step_Clock=0 next cycle, IDLE, PC=0; Start restarts at entry 0.
// - Entries all halt=0, DEPTH=4 -> stops HALTED at PC=3, no wrap.
//   Prog_Write_En while Busy leaves memory unchanged (read back via rerun).
// - Reset asserted mid-PULSE_HI -> Step_Clock low in same cycle; all outputs at reset values.

Source files
------------

// File: rtl/program_step_sequencer.sv
// program_step_sequencer: replays a stored program of switch words into
// the processor, pressing its clock button once per entry.
module program_step_sequencer #(
   parameter int DEPTH        = 64,
   parameter int ADDR_W       = $clog2(DEPTH),
   parameter int SETUP_CYCLES = 4,
   parameter int PULSE_CYCLES = 2_500_000,
   parameter int GAP_CYCLES   = 2_500_000,
   parameter int DONE_TIMEOUT = 5_000_000
) (
   input  logic              Clock_50MHz,
   input  logic              Reset,
   input  logic              Prog_Write_En,
   input  logic [ADDR_W-1:0] Prog_Write_Addr,
   input  logic [11:0]       Prog_Write_Data,
   input  logic              Start,
   input  logic              Single_Step,
   input  logic              Step_Request,
   input  logic              Abort,
   input  logic              Proc_Done,
   output logic [9:0]        Switch_Data,
   output logic              Step_Clock,
   output logic              Busy,
   output logic              Halted,
   output logic              Error,
   output logic [ADDR_W-1:0] PC
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE_HI,
      S_PULSE_LO,
      S_WAIT_DONE,
      S_PAUSE,
      S_HALTED,
      S_ERROR
   } state_t;

   localparam int SP_MAX =
      (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int PH_MAX =
      (SP_MAX > GAP_CYCLES) ? SP_MAX : GAP_CYCLES;
   localparam int CNT_W = $clog2(PH_MAX + 1);
   localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(DONE_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(DEPTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   ph_cnt;
   logic [TO_W-1:0]    to_cnt;
   logic               done_seen;
   logic               done_meta;
   logic               done_sync;

   logic [11:0]        mem [DEPTH];

   logic [ADDR_W-1:0]  pc_inc;
   logic [9:0]         word_first;
   logic [9:0]         word_cur;
   logic [9:0]         word_next;
   logic               cur_halt;
   logic               cur_expect;

   logic               wr_ok;
   logic               gap_end;
   logic               done_ok;
   logic               wait_chk;
   logic               advance;
   logic               timeout;
   logic               last_entry;

   assign pc_inc     = PC + ADDR_W'(1);
   assign word_first = mem[0][9:0];
   assign word_cur   = mem[PC][9:0];
   assign word_next  = mem[pc_inc][9:0];
   assign cur_halt   = mem[PC][11];
   assign cur_expect = mem[PC][10];

   // Program image: written only while the sequencer is not running.
   always_ff @(posedge Clock_50MHz) begin
      if (Prog_Write_En && wr_ok) begin
         mem[Prog_Write_Addr] <= Prog_Write_Data;
      end
   end

   // Bring the processor's Done LED into our clock domain.
   always_ff @(posedge Clock_50MHz or posedge Reset) begin
      if (Reset) begin
         done_meta <= 1'b0;
         done_sync <= 1'b0;
      end else begin
         done_meta <= Proc_Done;
         done_sync <= done_meta;
      end
   end

   // Decide this cycle's step-completion and timeout events.
   always_comb begin
      wr_ok      = 1'b0;
      gap_end    = 1'b0;
      done_ok    = 1'b0;
      wait_chk   = 1'b0;
      advance    = 1'b0;
      timeout    = 1'b0;
      last_entry = 1'b0;
      wr_ok      = (state == S_IDLE) || (state == S_HALTED) ||
                   (state == S_ERROR);
      gap_end    = (state == S_PULSE_LO) && (ph_cnt == GAP_LAST);
      done_ok    = done_seen || done_sync;
      wait_chk   = (state == S_WAIT_DONE) || (gap_end && cur_expect);
      advance    = (gap_end && (!cur_expect || done_ok)) ||
                   ((state == S_WAIT_DONE) && done_sync);
      timeout    = wait_chk && !done_ok && (to_cnt == TO_LAST);
      last_entry = cur_halt || (PC == PC_LAST);
   end

   // Sequencer FSM with registered button, data and status outputs.
   always_ff @(posedge Clock_50MHz or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         PC          <= '0;
         Switch_Data <= '0;
         Step_Clock  <= 1'b0;
         Busy        <= 1'b0;
         Halted      <= 1'b0;
         Error       <= 1'b0;
         ph_cnt      <= '0;
         to_cnt      <= '0;
         done_seen   <= 1'b0;
      end else if (Abort) begin
         state       <= S_IDLE;
         PC          <= '0;
         Switch_Data <= '0;
         Step_Clock  <= 1'b0;
         Busy        <= 1'b0;
         Halted      <= 1'b0;
         Error       <= 1'b0;
         ph_cnt      <= '0;
         to_cnt      <= '0;
         done_seen   <= 1'b0;
      end else if (timeout) begin
         state <= S_ERROR;
         Error <= 1'b1;
         Busy  <= 1'b0;
      end else if (advance) begin
         ph_cnt <= '0;
         if (last_entry) begin
            state  <= S_HALTED;
            Halted <= 1'b1;
            Busy   <= 1'b0;
         end else begin
            PC <= pc_inc;
            if (Single_Step) begin
               state <= S_PAUSE;
            end else begin
               state       <= S_SETUP;
               Switch_Data <= word_next;
            end
         end
      end else begin
         unique case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
               if (Start) begin
                  state       <= S_SETUP;
                  PC          <= '0;
                  Switch_Data <= word_first;
                  Busy        <= 1'b1;
                  Halted      <= 1'b0;
                  Error       <= 1'b0;
                  ph_cnt      <= '0;
               end
            end
            S_SETUP: begin
               if (ph_cnt == SETUP_LAST) begin
                  state      <= S_PULSE_HI;
                  Step_Clock <= 1'b1;
                  ph_cnt     <= '0;
               end else begin
                  ph_cnt <= ph_cnt + CNT_W'(1);
               end
            end
            S_PULSE_HI: begin
               if (ph_cnt == PULSE_LAST) begin
                  state      <= S_PULSE_LO;
                  Step_Clock <= 1'b0;
                  ph_cnt     <= '0;
                  to_cnt     <= '0;
                  done_seen  <= 1'b0;
               end else begin
                  ph_cnt <= ph_cnt + CNT_W'(1);
               end
            end
            S_PULSE_LO: begin
               ph_cnt <= ph_cnt + CNT_W'(1);
               to_cnt <= to_cnt + TO_W'(1);
               if (done_sync) begin
                  done_seen <= 1'b1;
               end
               if (gap_end) begin
                  state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               to_cnt <= to_cnt + TO_W'(1);
            end
            S_PAUSE: begin
               if (Step_Request) begin
                  state       <= S_SETUP;
                  Switch_Data <= word_cur;
                  ph_cnt      <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_step_sequencer.sv
// tb_program_step_sequencer: scoreboard bench for the step sequencer.
// Expected pulse words are queued at stimulus time and popped per pulse.
module tb_program_step_sequencer;

   localparam int PULSE = 4;
   localparam int TMO   = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [1:0]  wa;
   logic [11:0] wd;
   logic        start;
   logic        single_step;
   logic        step_req;
   logic        abort;
   logic        proc_done;
   logic [9:0]  switch_data;
   logic        step_clock;
   logic        busy;
   logic        halted;
   logic        error;
   logic [1:0]  pc;

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_q [$];
   logic [9:0] exp_w;
   logic [9:0] cap;
   int  cyc        = 0;
   int  rises      = 0;
   int  last_fall  = 0;
   int  hi_len     = 0;
   int  done_after = 0;
   int  lat;
   int  n;
   bit  prev_sc    = 1'b0;
   bit  cut_pulse  = 1'b0;
   bit  done_en    = 1'b0;

   always #5 clk = ~clk;

   program_step_sequencer #(
      .DEPTH        (4),
      .SETUP_CYCLES (2),
      .PULSE_CYCLES (PULSE),
      .GAP_CYCLES   (4),
      .DONE_TIMEOUT (TMO)
   ) dut (
      .Clock_50MHz     (clk),
      .Reset           (rst),
      .Prog_Write_En   (we),
      .Prog_Write_Addr (wa),
      .Prog_Write_Data (wd),
      .Start           (start),
      .Single_Step     (single_step),
      .Step_Request    (step_req),
      .Abort           (abort),
      .Proc_Done       (proc_done),
      .Switch_Data     (switch_data),
      .Step_Clock      (step_clock),
      .Busy            (busy),
      .Halted          (halted),
      .Error           (error),
      .PC              (pc)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: pops expected word on each rise, checks width on fall.
   always @(posedge clk) begin
      #1;
      if (step_clock && !prev_sc) begin
         rises++;
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(switch_data), 32'h3ff_ffff);
         end else begin
            exp_w = exp_q.pop_front();
            chk("pulse_data", 32'(switch_data), 32'(exp_w));
         end
         cap    = switch_data;
         hi_len = 1;
      end else if (step_clock) begin
         hi_len++;
         chk("data_stable", 32'(switch_data), 32'(cap));
      end else if (prev_sc) begin
         last_fall = cyc;
         if (!cut_pulse) chk("pulse_len", 32'(hi_len), 32'(PULSE));
         cut_pulse = 1'b0;
         if (done_en && rises == done_after) proc_done = 1'b1;
      end
      prev_sc = step_clock;
   end

   task automatic write_entry(input logic [1:0] a, input logic [11:0] d);
      @(negedge clk);
      we = 1'b1;
      wa = a;
      wd = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic start_run(output int l);
      @(negedge clk);
      rises = 0;
      start = 1'b1;
      l = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         l++;
         start = 1'b0;
         if (step_clock) break;
      end
   endtask

   task automatic wait_halted(input int budget, input string tag);
      int k = 0;
      while (!halted && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(tag, 32'(halted), 32'd1);
   endtask

   task automatic wait_pc(input logic [1:0] target, input int budget,
                          input string tag);
      int k = 0;
      while (pc !== target && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(tag, 32'(pc), 32'(target));
   endtask

   task automatic push3();
      exp_q.push_back(10'h010);
      exp_q.push_back(10'h155);
      exp_q.push_back(10'h000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
      start = 1'b0; single_step = 1'b0; step_req = 1'b0;
      abort = 1'b0; proc_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sw", 32'(switch_data), 32'd0);
      chk("rst_sc", 32'(step_clock), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      write_entry(2'd0, 12'h010);
      write_entry(2'd1, 12'h155);
      write_entry(2'd2, 12'hC00);

      // normal run, Done arrives after third pulse
      done_en = 1'b1; done_after = 3; proc_done = 1'b0;
      push3();
      start_run(lat);
      chk("t1_latency", 32'(lat), 32'd3);
      wait_halted(100, "t1_halted");
      chk("t1_pc", 32'(pc), 32'd2);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_rises", 32'(rises), 32'd3);
      chk("t1_queue", 32'(exp_q.size()), 32'd0);

      // Done never arrives
      done_en = 1'b0; proc_done = 1'b0;
      push3();
      start_run(lat);
      chk("t2_latency", 32'(lat), 32'd3);
      n = 0;
      while (!error && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t2_error", 32'(error), 32'd1);
      chk("t2_err_delay", 32'(cyc - last_fall), 32'(TMO));
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_halted", 32'(halted), 32'd0);
      chk("t2_pc", 32'(pc), 32'd2);
      chk("t2_rises", 32'(rises), 32'd3);

      // single step
      single_step = 1'b1;
      exp_q.push_back(10'h010);
      start_run(lat);
      chk("t3_latency", 32'(lat), 32'd3);
      chk("t3_error_clr", 32'(error), 32'd0);
      wait_pc(2'd1, 40, "t3_pause_pc");
      repeat (20) @(posedge clk);
      #1;
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_sc", 32'(step_clock), 32'd0);
      chk("t3_rises_held", 32'(rises), 32'd1);
      chk("t3_pc_held", 32'(pc), 32'd1);
      exp_q.push_back(10'h155);
      @(negedge clk);
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      wait_pc(2'd2, 40, "t3_pc2");
      chk("t3_rises2", 32'(rises), 32'd2);
      @(negedge clk);
      abort = 1'b1;
      single_step = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      chk("t3_abort_pc", 32'(pc), 32'd0);
      chk("t3_abort_busy", 32'(busy), 32'd0);

      // abort mid-pulse
      exp_q.push_back(10'h010);
      start_run(lat);
      chk("t4_latency", 32'(lat), 32'd3);
      cut_pulse = 1'b1;
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_sc", 32'(step_clock), 32'd0);
      chk("t4_pc", 32'(pc), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_sw", 32'(switch_data), 32'd0);
      @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("t4_abort_beats_start", 32'(busy), 32'd0);
      done_en = 1'b1; done_after = 3; proc_done = 1'b0;
      push3();
      start_run(lat);
      chk("t4_restart_latency", 32'(lat), 32'd3);
      wait_halted(100, "t4_halted");
      chk("t4_restart_pc", 32'(pc), 32'd2);
      chk("t4_restart_rises", 32'(rises), 32'd3);

      // full depth, no halt bits, write while busy
      done_en = 1'b0; proc_done = 1'b0;
      write_entry(2'd0, 12'h001);
      write_entry(2'd1, 12'h002);
      write_entry(2'd2, 12'h003);
      write_entry(2'd3, 12'h004);
      for (int i = 1; i <= 4; i++) exp_q.push_back(10'(i));
      start_run(lat);
      chk("t5_latency", 32'(lat), 32'd3);
      write_entry(2'd1, 12'h3FF);
      wait_halted(200, "t5_halted");
      chk("t5_pc", 32'(pc), 32'd3);
      chk("t5_rises", 32'(rises), 32'd4);
      for (int i = 1; i <= 4; i++) exp_q.push_back(10'(i));
      start_run(lat);
      wait_halted(200, "t5_rerun_halted");
      chk("t5_rerun_pc", 32'(pc), 32'd3);
      chk("t5_rerun_rises", 32'(rises), 32'd4);

      // async reset mid-pulse
      exp_q.push_back(10'h001);
      start_run(lat);
      chk("t6_latency", 32'(lat), 32'd3);
      cut_pulse = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("t6_sc", 32'(step_clock), 32'd0);
      chk("t6_sw", 32'(switch_data), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_pc", 32'(pc), 32'd0);
      chk("t6_halted", 32'(halted), 32'd0);
      chk("t6_error", 32'(error), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("end_queue", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
